// File: rtl/ahb_adc_dma_master_pkg.sv
// rtl/ahb_adc_dma_master_pkg.sv - AHB encodings, FSM state codes and address helper
// Purpose: shared AHB-Lite encodings and FSM states for the ADC DMA master.
// Ports: none (package).
package ahb_adc_dma_master_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_ERR   = 2'd3
  } state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [3:0] HPROT_DATA    = 4'b0011;

  // Byte address of word number idx; wraps modulo 2^32.
  function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [31:0] idx);
    return base + (idx << 2);
  endfunction

endpackage

// File: rtl/ahb_adc_dma_master_sample_fifo.sv
// rtl/ahb_adc_dma_master_sample_fifo.sv - synchronous sample FIFO with clear and occupancy
// Purpose: small circular buffer for ADC samples.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   clear               empties the FIFO
//   push, push_data     write strobe/data (caller guarantees not full)
//   pop, pop_data       read strobe (caller guarantees not empty) / head entry
//   full, empty, level  status and occupancy
module sample_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage needs no reset; pointers define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign pop_data = mem[rd_ptr];
  assign full     = (level == LVL_FULL);
  assign empty    = (level == '0);

endmodule

// File: rtl/ahb_adc_dma_master.sv
// rtl/ahb_adc_dma_master.sv - AHB-Lite master writing ADC samples to consecutive words
// Purpose: buffers ADC samples and writes each as a zero-extended word to base+4*n.
// Ports:
//   HCLK, HRESET                   clock, asynchronous active-high reset
//   cfg_start/cfg_base/cfg_count   job start pulse, byte base address, word count
//   adc_valid/adc_data             sample strobe and value
//   HADDR..HWDATA, HREADY, HRESP   AHB-Lite master interface (writes only)
//   busy, done, err, ovf           job status
module ahb_adc_dma_master
  import ahb_adc_dma_master_pkg::*;
#(
  parameter int DATA_WIDTH = 12,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  cfg_start,
  input  logic [31:0]           cfg_base,
  input  logic [CNT_WIDTH-1:0]  cfg_count,
  input  logic                  adc_valid,
  input  logic [DATA_WIDTH-1:0] adc_data,
  output logic [31:0]           HADDR,
  output logic [1:0]            HTRANS,
  output logic                  HWRITE,
  output logic [2:0]            HSIZE,
  output logic [2:0]            HBURST,
  output logic [3:0]            HPROT,
  output logic                  HMASTLOCK,
  output logic [31:0]           HWDATA,
  input  logic                  HREADY,
  input  logic                  HRESP,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  ovf
);

  state_t state, state_nx;

  logic [31:0]           base_q;
  logic [CNT_WIDTH-1:0]  count_q;
  logic [CNT_WIDTH-1:0]  issued;
  logic                  addr_nonseq;  // a NONSEQ is on the address bus
  logic                  dphase;       // a write data phase is in progress
  logic [31:0]           haddr_q;
  logic [31:0]           hwdata_q;
  logic [DATA_WIDTH-1:0] hold_q;       // sample belonging to the pending address phase

  logic                  fifo_full, fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_dout;
  logic [$clog2(FIFO_DEPTH):0] fifo_level;
  logic                  unused_fifo;

  logic start_acc, push_en, push_drop, issue, err_hit, finish;

  sample_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (HCLK),
    .rst       (HRESET),
    .clear     (start_acc),
    .push      (push_en),
    .push_data (adc_data),
    .pop       (issue),
    .pop_data  (fifo_dout),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  assign unused_fifo = ^fifo_level;

  // State register
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (start_acc) state_nx = (cfg_count == '0) ? ST_DRAIN : ST_RUN;
      ST_RUN: begin
        if (err_hit)                  state_nx = ST_ERR;
        else if (issued == count_q)   state_nx = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (err_hit)     state_nx = ST_ERR;
        else if (finish) state_nx = ST_IDLE;
      end
      ST_ERR:   if (HREADY) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // Control strobes decoded from state and bus inputs
  always_comb begin
    start_acc = 1'b0;
    push_en   = 1'b0;
    push_drop = 1'b0;
    issue     = 1'b0;
    err_hit   = 1'b0;
    finish    = 1'b0;
    case (state)
      ST_IDLE:  start_acc = cfg_start && !done;
      ST_RUN: begin
        // Acceptance looks only at occupancy before the edge; a same-cycle pop does not help.
        push_en   = adc_valid && !fifo_full;
        push_drop = adc_valid && fifo_full;
        err_hit   = dphase && HRESP && !HREADY;
        issue     = HREADY && !fifo_empty && (issued < count_q);
      end
      ST_DRAIN: begin
        err_hit = dphase && HRESP && !HREADY;
        // No address pending and HREADY high: the last data phase ends at this edge.
        finish  = HREADY && !addr_nonseq;
      end
      ST_ERR:   finish = HREADY;
      default:  ;
    endcase
  end

  // Job registers and AHB address/data phase pipeline
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      base_q      <= '0;
      count_q     <= '0;
      issued      <= '0;
      addr_nonseq <= 1'b0;
      dphase      <= 1'b0;
      haddr_q     <= '0;
      hwdata_q    <= '0;
      hold_q      <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      ovf         <= 1'b0;
    end else begin
      done <= finish;
      if (finish) busy <= 1'b0;
      if (start_acc) begin
        base_q  <= cfg_base & ~32'h3;
        count_q <= cfg_count;
        issued  <= '0;
        busy    <= 1'b1;
        err     <= 1'b0;
        ovf     <= 1'b0;
      end
      if (push_drop) ovf <= 1'b1;
      if (err_hit) begin
        // First error cycle: withdraw any pending address phase.
        err         <= 1'b1;
        addr_nonseq <= 1'b0;
      end else if (HREADY) begin
        addr_nonseq <= issue;
        dphase      <= addr_nonseq;
        if (addr_nonseq) hwdata_q <= 32'(hold_q);
        if (issue) begin
          haddr_q <= word_addr(base_q, 32'(issued));
          issued  <= issued + 1'b1;
          hold_q  <= fifo_dout;
        end
      end
    end
  end

  assign HADDR     = haddr_q;
  assign HTRANS    = addr_nonseq ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign HWRITE    = addr_nonseq;
  assign HSIZE     = HSIZE_WORD;
  assign HBURST    = HBURST_SINGLE;
  assign HPROT     = HPROT_DATA;
  assign HMASTLOCK = 1'b0;
  assign HWDATA    = hwdata_q;

endmodule
